// File: rtl/stream_hash.sv
// ---------------------------------------------------------------------------
// stream_hash
// Streaming hash engine: FNV-1a-style word absorb followed by a two-cycle
// xorshift/multiply finaliser. One message in flight at a time. Valid/ready
// handshakes on the word input and on the digest output.
//
// Build option:
//   HASH_LEN_MIX_EN - when defined, the saturating 16-bit message length is
//                     XORed into the state on entry to the finaliser, so that
//                     messages differing only in trailing zero words hash
//                     differently. When undefined the length counter is absent.
// ---------------------------------------------------------------------------
module stream_hash #(
    parameter int          DATA_W = 32,
    parameter int          HASH_W = 32,
    parameter logic [31:0] SEED   = 32'h811C9DC5,
    parameter logic [31:0] MULT   = 32'h01000193
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_data,
    input  logic              io_in_last,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [HASH_W-1:0] io_out_data,
    output logic              io_busy
);

    // Half-width shift used by both xorshift steps.
    localparam int S = DATA_W / 2;

    // Seed and multiplier resized to the state width.
    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] MULT_W = DATA_W'(MULT);

    typedef enum logic [1:0] {
        ST_ABSORB = 2'd0,
        ST_FIN1   = 2'd1,
        ST_FIN2   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Fold the upper half of a word onto the lower half.
    function automatic logic [DATA_W-1:0] xorshift(input logic [DATA_W-1:0] x);
        return x ^ (x >> S);
    endfunction

    state_t              state_r;
    logic [DATA_W-1:0]   h_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [HASH_W-1:0]   out_data_r;
    logic                busy_r;

    logic                accept_s;
    logic [DATA_W-1:0]   absorb_s;
    logic [DATA_W-1:0]   mix_s;
    logic [DATA_W-1:0]   fin1_s;
    logic [DATA_W-1:0]   mult2_s;
    logic [DATA_W-1:0]   fin2_s;

`ifdef HASH_LEN_MIX_EN
    logic [15:0]         len_r;
    logic [15:0]         len_next_s;

    // Length mixed into the state before the first finaliser step; counter saturates.
    always_comb begin
        mix_s = h_r ^ DATA_W'(len_r);
        if (len_r == 16'hFFFF) begin
            len_next_s = len_r;
        end else begin
            len_next_s = len_r + 16'd1;
        end
    end
`else
    // Without length mixing the finaliser sees the absorbed state directly.
    always_comb begin
        mix_s = h_r;
    end
`endif

    // Datapath: absorb step and both finaliser steps, computed from the current state.
    always_comb begin
        accept_s = io_in_valid & in_ready_r;
        absorb_s = (h_r ^ io_in_data) * MULT_W;
        fin1_s   = xorshift(mix_s);
        mult2_s  = h_r * MULT_W;
        fin2_s   = xorshift(mult2_s);
    end

    // Control FSM; owns the hash state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_ABSORB;
            h_r         <= SEED_W;
`ifdef HASH_LEN_MIX_EN
            len_r       <= 16'd0;
`endif
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {HASH_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_ABSORB: begin
                    if (accept_s) begin
                        h_r   <= absorb_s;
`ifdef HASH_LEN_MIX_EN
                        len_r <= len_next_s;
`endif
                        if (io_in_last) begin
                            state_r    <= ST_FIN1;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                ST_FIN1: begin
                    h_r     <= fin1_s;
                    state_r <= ST_FIN2;
                end
                ST_FIN2: begin
                    out_data_r  <= fin2_s[HASH_W-1:0];
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (io_out_ready) begin
                        out_valid_r <= 1'b0;
                        h_r         <= SEED_W;
`ifdef HASH_LEN_MIX_EN
                        len_r       <= 16'd0;
`endif
                        state_r     <= ST_ABSORB;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_ABSORB;
                    h_r         <= SEED_W;
`ifdef HASH_LEN_MIX_EN
                    len_r       <= 16'd0;
`endif
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign io_in_ready  = in_ready_r;
    assign io_out_valid = out_valid_r;
    assign io_out_data  = out_data_r;
    assign io_busy      = busy_r;

endmodule

// File: tb/tb_stream_hash.sv
// ---------------------------------------------------------------------------
// tb_stream_hash
// Self-checking bench for stream_hash. A reference model computes each
// digest as words are accepted and pushes it to a queue; digests are popped
// and compared when the engine presents them. A second instance with
// SEED=0/MULT=1 exercises the parameterisation.
// ---------------------------------------------------------------------------
module tb_stream_hash;

    localparam logic [31:0] D_SEED = 32'h811C9DC5;
    localparam logic [31:0] D_MULT = 32'h01000193;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_data2 = 32'd0;
    logic        in_last2 = 1'b0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_data2;
    logic        busy2;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mdl_h = D_SEED;
    int          mdl_len = 0;

    always #5 clk = ~clk;

    stream_hash dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_data   (in_data),
        .io_in_last   (in_last),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_data  (out_data),
        .io_busy      (busy)
    );

    stream_hash #(.SEED(32'h0000_0000), .MULT(32'h0000_0001)) dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_in_valid  (in_valid2),
        .io_in_ready  (in_ready2),
        .io_in_data   (in_data2),
        .io_in_last   (in_last2),
        .io_out_valid (out_valid2),
        .io_out_ready (out_ready2),
        .io_out_data  (out_data2),
        .io_busy      (busy2)
    );

    function automatic logic [31:0] mdl_absorb(input logic [31:0] h, input logic [31:0] w);
        return (h ^ w) * D_MULT;
    endfunction

    function automatic logic [31:0] mdl_final(input logic [31:0] h, input int len);
        logic [31:0] x;
        logic [31:0] m;
        x = h;
`ifdef HASH_LEN_MIX_EN
        x = x ^ 32'(len);
`endif
        x = x ^ (x >> 16);
        m = x * D_MULT;
        return m ^ (m >> 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word until accepted; update the model and queue on acceptance.
    task automatic send_word(input logic [31:0] d, input logic l);
        bit acc;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 40 && !done; i++) begin
            acc = in_ready;
            tick();
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_word timeout: word=%h not accepted within 40 cycles", d);
        end else begin
            mdl_h = mdl_absorb(mdl_h, d);
            mdl_len++;
            if (l) begin
                exp_q.push_back(mdl_final(mdl_h, mdl_len));
                mdl_h = D_SEED;
                mdl_len = 0;
            end
        end
    endtask

    // Wait (bounded) for the digest to be presented.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_valid timeout: io_out_valid stayed 0 for 20 cycles");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b want=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data: got=%h want=00000000", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        logic [31:0] e;
        send_word(32'h0000_0000, 1'b1);
        total++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL single_fin1: ready=%b busy=%b valid=%b want 0/1/0", in_ready, busy, out_valid);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_edge1_valid: got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_edge2_valid: got=%b want=1", out_valid); end
        e = exp_q.pop_front();
        total++; if (out_data !== e) begin bad++; $display("FAIL single_digest_model: got=%h want=%h", out_data, e); end
`ifndef HASH_LEN_MIX_EN
        total++; if (out_data !== 32'h056EA087) begin bad++; $display("FAIL single_digest_const: got=%h want=056ea087", out_data); end
`endif
        drain();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_handshake: valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_params();
        bit ok;
        logic [31:0] e;
`ifdef HASH_LEN_MIX_EN
        e = 32'h1234_5679;
`else
        e = 32'h1234_5678;
`endif
        in_valid2 = 1'b1;
        in_data2  = 32'h1234_5678;
        in_last2  = 1'b1;
        tick();
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (out_valid2) ok = 1'b1;
            else tick();
        end
        total++; if (!ok || out_data2 !== e) begin
            bad++; $display("FAIL params_digest: valid=%b got=%h want=%h", out_valid2, out_data2, e);
        end
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    task automatic test_toggle_valid();
        bit ok;
        logic [31:0] e;
        for (int k = 0; k < 4; k++) begin
            send_word($urandom, (k == 3));
            if (k < 3) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'b1;
                tick();
                in_last  = 1'b0;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL toggle_idle_absorb: busy=%b want=0 at word %0d", busy, k); end
            end
        end
        wait_valid(ok);
        if (ok) begin
            e = exp_q.pop_front();
            total++; if (out_data !== e) begin bad++; $display("FAIL toggle_digest: got=%h want=%h", out_data, e); end
            drain();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] e;
        send_word(32'hDEAD_BEEF, 1'b1);
        wait_valid(ok);
        if (ok) begin
            e = exp_q.pop_front();
            in_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                in_data = $urandom;
                total++; if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
                    bad++; $display("FAIL stall_cycle%0d: valid=%b data=%h ready=%b want 1/%h/0", i, out_valid, out_data, in_ready, e);
                end
                tick();
            end
            in_valid = 1'b0;
            drain();
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++; $display("FAIL stall_release: ready=%b valid=%b want 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int first;
        int second;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] e;
        first = -1;
        second = -1;
        d1 = 32'd0;
        d2 = 32'd0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0F0F;
        in_last   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            acc = in_ready;
            tick();
            if (acc) exp_q.push_back(mdl_final(mdl_absorb(D_SEED, 32'hA5A5_0F0F), 1));
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if (out_data !== e) begin bad++; $display("FAIL b2b_digest_at%0d: got=%h want=%h", i, out_data, e); end
                if (first < 0) begin first = i; d1 = out_data; end
                else if (second < 0) begin second = i; d2 = out_data; end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if (out_data !== e) begin bad++; $display("FAIL b2b_tail_digest: got=%h want=%h", out_data, e); end
            end
        end
        out_ready = 1'b0;
        total++; if (first < 0 || second - first != 4) begin
            bad++; $display("FAIL b2b_spacing: first=%0d second=%0d want gap 4", first, second);
        end
        total++; if (d1 !== d2) begin bad++; $display("FAIL b2b_identical: first=%h second=%h", d1, d2); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_queue_left: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] e;
        send_word(32'h1111_2222, 1'b0);
        send_word(32'h3333_4444, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: valid=%b data=%h ready=%b busy=%b want 0/0/1/0", out_valid, out_data, in_ready, busy);
        end
        mdl_h = D_SEED;
        mdl_len = 0;
        exp_q.delete();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        send_word(32'h0000_0000, 1'b1);
        wait_valid(ok);
        if (ok) begin
            e = exp_q.pop_front();
            total++; if (out_data !== e) begin bad++; $display("FAIL midreset_digest: got=%h want=%h", out_data, e); end
`ifndef HASH_LEN_MIX_EN
            total++; if (out_data !== 32'h056EA087) begin bad++; $display("FAIL midreset_const: got=%h want=056ea087", out_data); end
`endif
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_params();
        test_toggle_valid();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
